// File: rtl/fsk_demod_frame.sv
// fsk_demod_frame: oversampling FSK demodulator. Rising edges are counted per bit
// window, each window is decided against THRESH, and CODE_W bits form an MSB-first codeword.
module fsk_demod_frame #(
    parameter int CODE_W   = 14,
    parameter int BIT_CLKS = 32,
    parameter int THRESH   = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fsk_in,
    output logic              bit_data,
    output logic              bit_valid,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              carrier_lost,
    output logic              busy
);
    localparam int WCNT_W = $clog2(BIT_CLKS);
    localparam int BIDX_W = $clog2(CODE_W);
    localparam logic [CNT_W-1:0]  EDGE_MAX = '1;
    localparam logic [CNT_W-1:0]  ECNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  THRESH_V = CNT_W'(THRESH);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(BIT_CLKS - 1);
    localparam logic [BIDX_W-1:0] BIT_LAST = BIDX_W'(CODE_W - 1);

    typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

    state_t              state;
    logic                s1, s2, s3;
    logic                rise;
    logic [WCNT_W-1:0]   wcnt;
    logic [CNT_W-1:0]    ecnt;
    logic [CNT_W-1:0]    ecnt_next;
    logic [BIDX_W-1:0]   bidx;
    logic [CODE_W-2:0]   shreg;
    logic [CODE_W-1:0]   shift_next;
    logic                bit_dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= fsk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    // Saturating count that already includes an edge in the current cycle, so a
    // closing-cycle edge lands in the window being closed.
    assign ecnt_next  = (rise && (ecnt != EDGE_MAX)) ? ecnt + 1'b1 : ecnt;
    assign bit_dec    = (ecnt_next >= THRESH_V);
    assign shift_next = {shreg, bit_dec};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wcnt         <= '0;
            ecnt         <= '0;
            bidx         <= '0;
            shreg        <= '0;
            code         <= '0;
            code_valid   <= 1'b0;
            bit_data     <= 1'b0;
            bit_valid    <= 1'b0;
            carrier_lost <= 1'b0;
            busy         <= 1'b0;
        end else begin
            bit_valid    <= 1'b0;
            code_valid   <= 1'b0;
            carrier_lost <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= HUNT;
                        busy  <= 1'b1;
                    end
                end
                HUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rise) begin
                        state <= RECV;
                        wcnt  <= '0;
                        ecnt  <= ECNT_ONE;
                        bidx  <= '0;
                    end
                end
                RECV: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wcnt == WIN_LAST) begin
                        wcnt <= '0;
                        ecnt <= '0;
                        if (ecnt_next == '0) begin
                            carrier_lost <= 1'b1;
                            state        <= HUNT;
                        end else begin
                            bit_data  <= bit_dec;
                            bit_valid <= 1'b1;
                            shreg     <= shift_next[CODE_W-2:0];
                            // Last bit of the frame: publish and roll straight into the next frame.
                            if (bidx == BIT_LAST) begin
                                code       <= shift_next;
                                code_valid <= 1'b1;
                                bidx       <= '0;
                            end else begin
                                bidx <= bidx + 1'b1;
                            end
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        ecnt <= ecnt_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_demod_frame.sv
// Directed testbench for fsk_demod_frame: drives sample-accurate FSK windows and
// checks decided bits, codewords and strobes against hand-computed values.
`timescale 1ns/1ps
module tb_fsk_demod_frame;
    localparam int CODE_W   = 14;
    localparam int BIT_CLKS = 32;
    localparam int THRESH   = 4;
    localparam int CNT_W    = 4;

    // Window patterns, bit i is the fsk_in sample i of the window; bit 0 is always 0.
    localparam logic [31:0] TONE_ONE  = 32'hCCCC_CCCC;
    localparam logic [31:0] TONE_ZERO = 32'hFF00_FF00;
    localparam logic [31:0] EDGES_3   = 32'h0000_002A;
    localparam logic [31:0] EDGES_4   = 32'h0000_00AA;
    localparam logic [31:0] EDGES_END = 32'hAA00_0000;
    localparam logic [31:0] EDGES_16  = 32'hAAAA_AAAA;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              fsk_in;
    logic              bit_data;
    logic              bit_valid;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              carrier_lost;
    logic              busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fsk_demod_frame #(
        .CODE_W(CODE_W), .BIT_CLKS(BIT_CLKS), .THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fsk_in(fsk_in),
        .bit_data(bit_data), .bit_valid(bit_valid), .code(code),
        .code_valid(code_valid), .carrier_lost(carrier_lost), .busy(busy)
    );

    // Strobe log sampled on the falling edge; tests compare against baselines.
    int                cycle = 0;
    logic              bits_log[$];
    logic [CODE_W-1:0] codes_log[$];
    int                code_cycles[$];
    int                lost_count = 0;
    int                overlap_count = 0;
    int                cv_repeat = 0;
    logic              prev_cv = 1'b0;

    always @(negedge clk) begin
        cycle++;
        if (bit_valid) bits_log.push_back(bit_data);
        if (code_valid) begin
            codes_log.push_back(code);
            code_cycles.push_back(cycle);
        end
        if (carrier_lost) lost_count++;
        if (code_valid && carrier_lost) overlap_count++;
        if (code_valid && prev_cv) cv_repeat++;
        prev_cv = code_valid;
    end

    task automatic send_sample(input logic v);
        @(negedge clk);
        fsk_in = v;
    endtask

    task automatic send_window(input logic [31:0] pattern);
        for (int i = 0; i < BIT_CLKS; i++) send_sample(pattern[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_sample(1'b0);
    endtask

    task automatic send_hunt();
        idle(3);
        send_sample(1'b1);
    endtask

    task automatic send_bits(input logic [CODE_W-1:0] value, input int n);
        for (int k = 0; k < n; k++) send_window(value[CODE_W-1-k] ? TONE_ONE : TONE_ZERO);
    endtask

    task automatic send_frame(input logic [CODE_W-1:0] value);
        send_hunt();
        send_bits(value, CODE_W);
    endtask

    task automatic start_rx();
        @(negedge clk);
        enable = 1'b1;
        idle(2);
    endtask

    task automatic stop_rx();
        @(negedge clk);
        enable = 1'b0;
        fsk_in = 1'b0;
        idle(2);
    endtask

    function automatic logic [CODE_W-1:0] collect_bits(input int base, input int n);
        logic [CODE_W-1:0] v = '0;
        for (int k = 0; k < n; k++)
            v = {v[CODE_W-2:0], (base + k < bits_log.size()) ? bits_log[base + k] : 1'bx};
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; fsk_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else passed++;
        checks++; if (code !== '0) $display("[TB] FAIL rst_code: got %h expected 0", code); else passed++;
        checks++; if (code_valid !== 1'b0) $display("[TB] FAIL rst_code_valid: got %b expected 0", code_valid); else passed++;
        checks++; if (bit_valid !== 1'b0) $display("[TB] FAIL rst_bit_valid: got %b expected 0", bit_valid); else passed++;
        checks++; if (bit_data !== 1'b0) $display("[TB] FAIL rst_bit_data: got %b expected 0", bit_data); else passed++;
        checks++; if (carrier_lost !== 1'b0) $display("[TB] FAIL rst_carrier_lost: got %b expected 0", carrier_lost); else passed++;

        @(negedge clk);
        reset = 1'b0; enable = 1'b1;
        idle(2);
        send_hunt();
        send_window(TONE_ONE);
        send_window(TONE_ONE);
        for (int i = 0; i < 5; i++) send_sample(TONE_ONE[i]);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL recv_busy: got %b expected 1", busy); else passed++;
        checks++; if (bit_data !== 1'b1) $display("[TB] FAIL recv_bit_data: got %b expected 1", bit_data); else passed++;

        @(posedge clk);
        #2 reset = 1'b1;
        fsk_in = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL async_busy: got %b expected 0", busy); else passed++;
        checks++; if (bit_data !== 1'b0) $display("[TB] FAIL async_bit_data: got %b expected 0", bit_data); else passed++;

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL release_busy: got %b expected 1", busy); else passed++;
    endtask

    task automatic test_single_frame();
        int bb = bits_log.size();
        int cb = codes_log.size();
        int lb = lost_count;
        send_frame(14'h2CE5);
        idle(5);
        checks++; if (codes_log.size() - cb !== 1) $display("[TB] FAIL single_code_count: got %0d expected 1", codes_log.size() - cb); else passed++;
        checks++; if (code !== 14'h2CE5) $display("[TB] FAIL single_code: got %h expected 2ce5", code); else passed++;
        checks++; if (bits_log.size() - bb !== 14) $display("[TB] FAIL single_bit_count: got %0d expected 14", bits_log.size() - bb); else passed++;
        checks++; if (collect_bits(bb, 14) !== 14'h2CE5) $display("[TB] FAIL single_bit_seq: got %h expected 2ce5", collect_bits(bb, 14)); else passed++;
        checks++; if (lost_count - lb !== 0) $display("[TB] FAIL single_lost: got %0d expected 0", lost_count - lb); else passed++;
        stop_rx();
        checks++; if (busy !== 1'b0) $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int bb, cb;
        start_rx();
        bb = bits_log.size();
        cb = codes_log.size();
        send_hunt();
        send_bits(14'h2CE5, CODE_W);
        send_bits(14'h1F00, CODE_W);
        idle(5);
        checks++; if (codes_log.size() - cb !== 2) $display("[TB] FAIL b2b_code_count: got %0d expected 2", codes_log.size() - cb); else passed++;
        if (codes_log.size() - cb >= 2) begin
            checks++; if (codes_log[cb] !== 14'h2CE5) $display("[TB] FAIL b2b_first: got %h expected 2ce5", codes_log[cb]); else passed++;
            checks++; if (codes_log[cb + 1] !== 14'h1F00) $display("[TB] FAIL b2b_second: got %h expected 1f00", codes_log[cb + 1]); else passed++;
            checks++; if (code_cycles[cb + 1] - code_cycles[cb] !== 448) $display("[TB] FAIL b2b_spacing: got %0d expected 448", code_cycles[cb + 1] - code_cycles[cb]); else passed++;
        end
        checks++; if (bits_log.size() - bb !== 28) $display("[TB] FAIL b2b_bit_count: got %0d expected 28", bits_log.size() - bb); else passed++;
        stop_rx();
    endtask

    task automatic test_threshold();
        int bb, lb;
        logic [4:0] got;
        start_rx();
        bb = bits_log.size();
        lb = lost_count;
        send_hunt();
        send_window(TONE_ONE);
        send_window(EDGES_3);
        send_window(EDGES_4);
        send_window(EDGES_END);
        send_window(EDGES_16);
        idle(5);
        got = 5'(collect_bits(bb, 5));
        checks++; if (bits_log.size() - bb !== 5) $display("[TB] FAIL thr_bit_count: got %0d expected 5", bits_log.size() - bb); else passed++;
        checks++; if (got[3] !== 1'b0) $display("[TB] FAIL thr_3_edges: got %b expected 0", got[3]); else passed++;
        checks++; if (got[2] !== 1'b1) $display("[TB] FAIL thr_4_edges: got %b expected 1", got[2]); else passed++;
        checks++; if (got[1] !== 1'b1) $display("[TB] FAIL thr_closing_edge: got %b expected 1", got[1]); else passed++;
        checks++; if (got[0] !== 1'b1) $display("[TB] FAIL thr_saturate: got %b expected 1", got[0]); else passed++;
        checks++; if (lost_count - lb !== 0) $display("[TB] FAIL thr_lost: got %0d expected 0", lost_count - lb); else passed++;
        stop_rx();
    endtask

    task automatic test_carrier_loss();
        int bb, cb, lb;
        start_rx();
        bb = bits_log.size();
        cb = codes_log.size();
        lb = lost_count;
        send_hunt();
        send_bits(14'h2CE5, 7);
        idle(36);
        checks++; if (lost_count - lb !== 1) $display("[TB] FAIL loss_pulses: got %0d expected 1", lost_count - lb); else passed++;
        checks++; if (codes_log.size() - cb !== 0) $display("[TB] FAIL loss_code_count: got %0d expected 0", codes_log.size() - cb); else passed++;
        checks++; if (bits_log.size() - bb !== 7) $display("[TB] FAIL loss_bit_count: got %0d expected 7", bits_log.size() - bb); else passed++;
        checks++; if (code !== 14'h1F00) $display("[TB] FAIL loss_code_held: got %h expected 1f00", code); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL loss_hunt_busy: got %b expected 1", busy); else passed++;
        cb = codes_log.size();
        send_frame(14'h2CE5);
        idle(5);
        checks++; if (codes_log.size() - cb !== 1) $display("[TB] FAIL loss_refr_count: got %0d expected 1", codes_log.size() - cb); else passed++;
        checks++; if (code !== 14'h2CE5) $display("[TB] FAIL loss_refr_code: got %h expected 2ce5", code); else passed++;
        stop_rx();
    endtask

    task automatic test_enable_drop();
        int bb, cb, lb;
        start_rx();
        bb = bits_log.size();
        cb = codes_log.size();
        lb = lost_count;
        send_hunt();
        send_bits(14'h1F00, 9);
        for (int i = 0; i < 10; i++) send_sample(TONE_ONE[i]);
        @(negedge clk);
        enable = 1'b0;
        fsk_in = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL drop_busy: got %b expected 0", busy); else passed++;
        idle(40);
        checks++; if (bits_log.size() - bb !== 9) $display("[TB] FAIL drop_bit_count: got %0d expected 9", bits_log.size() - bb); else passed++;
        checks++; if (codes_log.size() - cb !== 0) $display("[TB] FAIL drop_code_count: got %0d expected 0", codes_log.size() - cb); else passed++;
        checks++; if (lost_count - lb !== 0) $display("[TB] FAIL drop_lost: got %0d expected 0", lost_count - lb); else passed++;
        checks++; if (code !== 14'h2CE5) $display("[TB] FAIL drop_code_held: got %h expected 2ce5", code); else passed++;
        start_rx();
        cb = codes_log.size();
        send_frame(14'h1F00);
        idle(5);
        checks++; if (codes_log.size() - cb !== 1) $display("[TB] FAIL drop_refr_count: got %0d expected 1", codes_log.size() - cb); else passed++;
        checks++; if (code !== 14'h1F00) $display("[TB] FAIL drop_refr_code: got %h expected 1f00", code); else passed++;
        stop_rx();
    endtask

    task automatic test_strobe_rules();
        checks++; if (overlap_count !== 0) $display("[TB] FAIL strobe_exclusive: got %0d expected 0", overlap_count); else passed++;
        checks++; if (cv_repeat !== 0) $display("[TB] FAIL strobe_repeat: got %0d expected 0", cv_repeat); else passed++;
    endtask

    initial begin
        $display("[TB] fsk_demod_frame directed test start");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_threshold();
        test_carrier_loss();
        test_enable_drop();
        test_strobe_rules();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
